timer_sched: RTL and testbench

- Schedules one shared countdown timer core among NUM_REQ requesters.
- Each requester posts a tick count. The block grants requesters round-robin, loads and starts the core, waits for expiry and returns a one-cycle done pulse to the owner.
- Supports per-requester cancel with abort indication.
- Sits between firmware-facing timer channels and the single timer core instance.

---
 rtl/timer_sched.sv | 151 +++++++++++++++
 tb/tb_timer_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sched.sv
// Shares a single countdown timer core among NUM_REQ requesters with round-robin grant,
// cancel/abort handling and a one-cycle done pulse back to the owning requester.
module timer_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [32*NUM_REQ-1:0]   req_ticks_i,
    input  logic [NUM_REQ-1:0]      cancel_i,
    input  logic [31:0]             prescaler_i,
    output logic [NUM_REQ-1:0]      done_o,
    output logic                    aborted_o,
    output logic                    busy_o,
    output logic [ID_W-1:0]         grant_id_o,
    output logic [31:0]             core_prescaler_init_o,
    output logic [31:0]             core_timer_init_o,
    output logic                    core_start_stop_o,
    input  logic                    core_ready_i,
    input  logic [31:0]             core_curr_timer_i,
    output logic [31:0]             curr_timer_o
);

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StWaitBusy,
        StWaitDone,
        StStopWait,
        StComplete
    } state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [31:0]     tinit_q, tinit_d;
    logic [31:0]     pinit_q, pinit_d;
    logic            aborted_q, aborted_d;
    logic            cancel_pend_q, cancel_pend_d;

    logic            found;
    logic [ID_W-1:0] pick_id;
    logic [ID_W-1:0] rr_next;
    logic            owner_cancel;
    logic            start_stop;

    // First requesting index at or after the round-robin pointer, wrapping at NUM_REQ.
    always_comb begin
        int unsigned idx;
        found   = 1'b0;
        pick_id = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_q) + i) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found   = 1'b1;
                pick_id = ID_W'(idx);
            end
        end
        rr_next = ID_W'((32'(pick_id) + 32'd1) % NUM_REQ);
    end

    assign owner_cancel = cancel_i[grant_q];

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        grant_d       = grant_q;
        tinit_d       = tinit_q;
        pinit_d       = pinit_q;
        aborted_d     = aborted_q;
        cancel_pend_d = cancel_pend_q;
        start_stop    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d       = pick_id;
                    tinit_d       = req_ticks_i[32*pick_id +: 32];
                    pinit_d       = prescaler_i;
                    aborted_d     = 1'b0;
                    cancel_pend_d = 1'b0;
                    rr_d          = rr_next;
                    state_d       = StGrant;
                end
            end
            StGrant: begin
                if (owner_cancel) cancel_pend_d = 1'b1;
                if (tinit_q == '0) begin
                    state_d = StComplete;
                end else if (core_ready_i) begin
                    start_stop = 1'b1;
                    state_d    = StWaitBusy;
                end
            end
            StWaitBusy: begin
                if (owner_cancel) cancel_pend_d = 1'b1;
                if (!core_ready_i) state_d = StWaitDone;
            end
            StWaitDone: begin
                // Expiry takes priority over a cancel arriving in the same cycle.
                if (core_ready_i) begin
                    state_d = StComplete;
                end else if (owner_cancel || cancel_pend_q) begin
                    start_stop = 1'b1;
                    aborted_d  = 1'b1;
                    state_d    = StStopWait;
                end
            end
            StStopWait: begin
                if (core_ready_i) state_d = StComplete;
            end
            StComplete: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            rr_q          <= '0;
            grant_q       <= '0;
            tinit_q       <= '0;
            pinit_q       <= '0;
            aborted_q     <= 1'b0;
            cancel_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            grant_q       <= grant_d;
            tinit_q       <= tinit_d;
            pinit_q       <= pinit_d;
            aborted_q     <= aborted_d;
            cancel_pend_q <= cancel_pend_d;
        end
    end

    assign busy_o                = (state_q != StIdle);
    assign done_o                = (state_q == StComplete) ? (NUM_REQ'(1) << grant_q) : '0;
    assign aborted_o             = aborted_q;
    assign grant_id_o            = grant_q;
    assign core_timer_init_o     = tinit_q;
    assign core_prescaler_init_o = pinit_q;
    assign core_start_stop_o     = start_stop;
    assign curr_timer_o          = busy_o ? core_curr_timer_i : 32'd0;

endmodule

// File: tb/tb_timer_sched.sv
// Randomized and directed bench for timer_sched with a behavioural timer core, a
// per-requester scoreboard of expected services and a negedge monitor.
module tb_timer_sched;
    localparam int NR = 4;
    localparam int IW = 2;

    typedef struct {
        int unsigned ticks;
        bit          abort;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req, cancel;
    logic [32*NR-1:0]  req_ticks;
    logic [31:0]       presc;
    logic              req_a[NR];
    logic              cancel_a[NR];
    logic [31:0]       ticks_a[NR];
    logic [NR-1:0]     done;
    logic              aborted, busy, start_stop, core_ready;
    logic [IW-1:0]     grant_id;
    logic [31:0]       core_pinit, core_tinit, curr_timer;
    logic              ready_q, core_hold;
    logic [31:0]       core_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        req       = '0;
        cancel    = '0;
        req_ticks = '0;
        for (int i = 0; i < NR; i++) begin
            req[i]                 = req_a[i];
            cancel[i]              = cancel_a[i];
            req_ticks[32*i +: 32]  = ticks_a[i];
        end
    end

    timer_sched #(.NUM_REQ(NR), .ID_W(IW)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .req_i                 (req),
        .req_ticks_i           (req_ticks),
        .cancel_i              (cancel),
        .prescaler_i           (presc),
        .done_o                (done),
        .aborted_o             (aborted),
        .busy_o                (busy),
        .grant_id_o            (grant_id),
        .core_prescaler_init_o (core_pinit),
        .core_timer_init_o     (core_tinit),
        .core_start_stop_o     (start_stop),
        .core_ready_i          (core_ready),
        .core_curr_timer_i     (core_cnt),
        .curr_timer_o          (curr_timer)
    );

    // Behavioural core: runs ticks*(prescaler+1) cycles; a stop takes 2 cycles to settle.
    assign core_ready = ready_q && !core_hold;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q  <= 1'b1;
            core_cnt <= 32'd0;
        end else if (start_stop) begin
            if (ready_q) begin
                ready_q  <= 1'b0;
                core_cnt <= core_tinit * (core_pinit + 32'd1);
            end else begin
                core_cnt <= 32'd2;
            end
        end else if (!ready_q) begin
            if (core_cnt > 32'd1) core_cnt <= core_cnt - 32'd1;
            else ready_q <= 1'b1;
        end
    end

    task automatic check_eq(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- scoreboard and monitor ----------------
    exp_t         exp_q[NR][$];
    exp_t         cur_exp;
    bit           have_exp = 0;
    int           model_rr = 0, cur_id = 0, cyc = 0, grant_cyc = 0, rise_cyc = 0, pulses = 0;
    logic [NR-1:0] prev_req = '0;
    logic [31:0]  prev_presc = '0;
    logic         prev_busy = 0, prev_ready = 1, prev_pulse = 0;

    always @(negedge clk) begin
        if (rst) begin
            model_rr   = 0;
            prev_busy  = 0;
            prev_pulse = 0;
            prev_ready = 1;
            pulses     = 0;
            have_exp   = 0;
        end else begin
            int gid;
            cyc++;
            check_eq("curr_timer", curr_timer, busy ? core_cnt : 32'd0);
            if (busy && !prev_busy) begin
                gid = -1;
                for (int k = 0; k < NR; k++) begin
                    if (gid < 0 && prev_req[(model_rr + k) % NR]) gid = (model_rr + k) % NR;
                end
                if (gid < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_no_req: got grant %0d with req %b", grant_id, prev_req);
                end else begin
                    check_eq("grant_id", grant_id, gid);
                    model_rr = (gid + 1) % NR;
                    cur_id   = gid;
                    if (exp_q[gid].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant: got %0d expected none", gid);
                    end else begin
                        cur_exp  = exp_q[gid].pop_front();
                        have_exp = 1;
                        check_eq("timer_init", core_tinit, cur_exp.ticks);
                        check_eq("presc_init", core_pinit, prev_presc);
                    end
                end
                grant_cyc = cyc;
                pulses    = 0;
            end
            if (start_stop) begin
                check_eq("pulse_back_to_back", prev_pulse, 0);
                if (pulses == 0) check_eq("start_needs_ready", core_ready, 1);
                pulses++;
            end
            if (core_ready && !prev_ready) rise_cyc = cyc;
            if (done != '0) begin
                check_eq("done_onehot", $countones(done), 1);
                check_eq("done_owner", done, NR'(1) << cur_id);
                if (have_exp) begin
                    check_eq("aborted", aborted, cur_exp.abort);
                    check_eq("pulse_count", pulses, (cur_exp.ticks != 0) + cur_exp.abort);
                    if (cur_exp.ticks != 0) check_eq("done_latency", cyc, rise_cyc + 1);
                    else check_eq("zero_tick_latency", cyc, grant_cyc + 1);
                    have_exp = 0;
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got %b expected none", done);
                end
            end
            prev_busy  = busy;
            prev_req   = req;
            prev_presc = presc;
            prev_ready = core_ready;
            prev_pulse = start_stop;
        end
    end

    // ---------------- requester stimulus ----------------
    // cmode: 0 none, 1 cancel cafter cycles into ownership, 2 cancel as core_ready rises.
    task automatic serve(input int i, input int unsigned t, input int cmode, input int cafter,
                         input bit exp_ab, input bit noise);
        exp_t e;
        int   n = 0, oc = 0;
        bit   fin = 0, prev_rdy = 1, fired = 0, seen_low = 0;
        e.ticks = t;
        e.abort = exp_ab;
        exp_q[i].push_back(e);
        ticks_a[i] = t;
        req_a[i]   = 1'b1;
        while (!fin && n < 6000) begin
            step();
            n++;
            cancel_a[i] = 1'b0;
            if (done[i]) begin
                fin      = 1;
                req_a[i] = 1'b0;
            end else if (busy && grant_id == IW'(i)) begin
                if (!core_ready) seen_low = 1;
                if (cmode == 1 && oc == cafter) cancel_a[i] = 1'b1;
                if (cmode == 2 && !fired && seen_low && core_ready && !prev_rdy) begin
                    cancel_a[i] = 1'b1;
                    fired       = 1;
                end
                oc++;
            end else if (noise && $urandom_range(7) == 0) begin
                cancel_a[i] = 1'b1;
            end
            prev_rdy = core_ready;
        end
        cancel_a[i] = 1'b0;
        req_a[i]    = 1'b0;
        if (!fin) check_eq("done_timeout", n, 0);
    endtask

    task automatic rand_req(input int i);
        int unsigned t;
        int          cm;
        repeat (6) begin
            cm = int'($urandom_range(2));
            t  = (cm == 1) ? $urandom_range(16, 10) : $urandom_range(12);
            serve(i, t, cm, int'($urandom_range(3)), cm == 1, 1'b1);
            step(int'($urandom_range(3)));
        end
    endtask

    bit rand_on = 0;
    int guard;

    initial begin
        presc     = '0;
        core_hold = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_a[i]    = 1'b0;
            cancel_a[i] = 1'b0;
            ticks_a[i]  = '0;
        end
        step(3);
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_aborted", aborted, 0);
        check_eq("rst_grant_id", grant_id, 0);
        check_eq("rst_start_stop", start_stop, 0);
        check_eq("rst_tinit", core_tinit, 0);
        check_eq("rst_pinit", core_pinit, 0);
        rst = 1'b0;
        step(2);

        // Round robin from rr=0 with all four, then a sparse pair.
        fork
            serve(0, 3, 0, 0, 0, 0);
            serve(1, 4, 0, 0, 0, 0);
            serve(2, 5, 0, 0, 0, 0);
            serve(3, 6, 0, 0, 0, 0);
        join
        step(2);
        fork
            serve(1, 2, 0, 0, 0, 0);
            serve(3, 2, 0, 0, 0, 0);
        join
        step(2);

        serve(1, 5, 0, 0, 0, 0);
        step(2);
        serve(2, 0, 0, 0, 0, 0);
        step(2);

        presc = 32'd3;
        serve(0, 1000, 1, 20, 1, 0);
        step(2);
        serve(1, 10, 1, 0, 1, 0);  // cancel during GRANT is held pending
        serve(2, 10, 1, 1, 1, 0);  // cancel during WAIT_BUSY is held pending
        presc = 32'd0;

        // Expiry/cancel race, with a non-owner cancel while 0 owns.
        fork
            serve(0, 8, 2, 0, 0, 0);
            begin
                step(4);
                cancel_a[2] = 1'b1;
                step();
                cancel_a[2] = 1'b0;
            end
        join
        step(2);

        // Core busy at grant: no start until it reports ready.
        core_hold = 1'b1;
        fork
            serve(3, 4, 0, 0, 0, 0);
            begin
                step(6);
                check_eq("hold_busy", busy, 1);
                core_hold = 1'b0;
            end
        join
        step(2);

        // Async reset while 1 owns in WAIT_DONE (rr would point at 2).
        begin
            exp_t e;
            e.ticks = 200;
            e.abort = 0;
            exp_q[1].push_back(e);
        end
        ticks_a[1] = 32'd200;
        req_a[1]   = 1'b1;
        guard = 0;
        while (!(busy && !core_ready) && guard < 50) begin
            step();
            guard++;
        end
        check_eq("reset_setup_timeout", guard < 50, 1);
        step(5);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_start_stop", start_stop, 0);
        check_eq("arst_grant_id", grant_id, 0);
        check_eq("arst_tinit", core_tinit, 0);
        req_a[1] = 1'b0;
        for (int i = 0; i < NR; i++) exp_q[i].delete();
        step(2);
        rst = 1'b0;
        step(2);
        fork
            serve(1, 3, 0, 0, 0, 0);
            serve(3, 3, 0, 0, 0, 0);
        join
        step(2);

        // Randomized concurrent traffic with varying prescaler.
        rand_on = 1;
        fork
            begin
                while (rand_on) begin
                    step();
                    presc = $urandom_range(3);
                end
            end
            begin
                fork
                    rand_req(0);
                    rand_req(1);
                    rand_req(2);
                    rand_req(3);
                join
                rand_on = 0;
            end
        join
        step(4);
        for (int i = 0; i < NR; i++) check_eq("sb_empty", exp_q[i].size(), 0);
        check_eq("end_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
